// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    QUALIFY = 2'd1,
    RUN     = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_LOSS_CNT_W    = 8;

  // Larger of two integers; sizes the counter shared by QUALIFY and HOLD.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Lock-in / reset-out bundle between the PLL reset sequencer and its consumer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface pll_reset_seq_if #(
  parameter int LOSS_CNT_W = 8
);

  logic                  locked_i;
  logic                  rst_o;
  logic                  ready_o;
  logic                  lock_loss_o;
  logic [LOSS_CNT_W-1:0] loss_count_o;

  // Sequencer side: consumes the raw lock, drives reset and status.
  modport master (
    input  locked_i,
    output rst_o,
    output ready_o,
    output lock_loss_o,
    output loss_count_o
  );

  // Consumer side: provides the raw lock, observes reset and status.
  modport slave (
    output locked_i,
    input  rst_o,
    input  ready_o,
    input  lock_loss_o,
    input  loss_count_o
  );

endinterface

// File: rtl/pll_reset_seq_sync_bits.sv
// N-stage single-bit synchronizer with synchronous clear, for any CDC point.
// Latency: STAGES cycles from i_d to o_q.
// Backpressure: none; samples every cycle.
module sync_bits #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the chain; clear forces all stages low.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Qualifies a synchronized PLL lock over a stability window, then releases rst_o; lock loss forces a minimum hold.
// Latency: rst_o falls STABLE_CYCLES+1 cycles after lock_s is first seen in WAIT; loss shows one cycle after lock_s drops.
// Backpressure: none. Optional PLL_LOSS_COUNT_EN builds the saturating loss counter, otherwise loss_count_o is tied to 0.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int LOSS_CNT_W    = DEF_LOSS_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  pll_reset_seq_if.master bus
);

  localparam int CNT_W = $clog2(max2(STABLE_CYCLES, HOLD_CYCLES));
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic             w_lock_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_loss_pend;
  logic             r_rst;
  logic             r_ready;
  logic             r_lock_loss;

  sync_bits #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .i_clr (reset),
    .i_d   (bus.locked_i),
    .o_q   (w_lock_s)
  );

  // Sequencer FSM; outputs are decoded from the previous state so they change only on state boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT;
      r_cnt       <= '0;
      r_loss_pend <= 1'b0;
      r_rst       <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_loss <= 1'b0;
    end else begin
      r_rst       <= (r_state != RUN);
      r_ready     <= (r_state == RUN);
      r_lock_loss <= r_loss_pend;
      r_loss_pend <= 1'b0;
      case (r_state)
        WAIT: begin
          r_cnt <= '0;
          if (w_lock_s) begin
            r_state <= QUALIFY;
          end
        end
        QUALIFY: begin
          if (!w_lock_s) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          r_cnt <= '0;
          if (!w_lock_s) begin
            r_state     <= HOLD;
            r_loss_pend <= 1'b1;
          end
        end
        HOLD: begin
          // Lock returning here is deliberately ignored: the hold always runs to completion.
          if (r_cnt == HOLD_LAST) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rst_o       = r_rst;
  assign bus.ready_o     = r_ready;
  assign bus.lock_loss_o = r_lock_loss;

`ifdef PLL_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // Count losses in step with the lock_loss_o pulse; stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loss_cnt <= '0;
    end else if (r_loss_pend && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign bus.loss_count_o = r_loss_cnt;
`else
  assign bus.loss_count_o = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomized and directed bench for pll_reset_seq against a streak/timer reference model.
// Latency: model predicts outputs one edge after the lock_s decision that causes them.
// Backpressure: n/a.
module tb_pll_reset_seq;

  localparam int SS = 2;
  localparam int SC = 16;
  localparam int HC = 4;
  localparam int LW = 8;
  localparam int CNT_MAX = (1 << LW) - 1;
`ifdef PLL_LOSS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pll_reset_seq_if #(.LOSS_CNT_W(LW)) bus ();

  pll_reset_seq #(
    .SYNC_STAGES   (SS),
    .STABLE_CYCLES (SC),
    .HOLD_CYCLES   (HC),
    .LOSS_CNT_W    (LW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int obs_pulses = 0;

  // Reference model: lock history delay line, a run flag, a hold timer and a streak of qualifying lock cycles.
  bit hist[$];
  bit m_run;
  bit m_loss_evt;
  int m_streak;
  int m_hold_left;
  bit e_rst;
  bit e_loss;
  int e_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst_in, input bit lk);
    bit lock_s;
    if (rst_in) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      m_run       = 1'b0;
      m_loss_evt  = 1'b0;
      m_streak    = 0;
      m_hold_left = 0;
      e_rst       = 1'b1;
      e_loss      = 1'b0;
      e_cnt       = 0;
      return;
    end
    lock_s = hist.pop_front();
    hist.push_back(lk);
    // Outputs visible after this edge reflect the decision taken at the previous edge.
    e_rst  = !m_run;
    e_loss = m_loss_evt;
    if (m_loss_evt && CNT_EN && e_cnt < CNT_MAX) e_cnt++;
    m_loss_evt = 1'b0;
    if (m_hold_left > 0) begin
      m_hold_left--;
      m_streak = 0;
    end else if (m_run) begin
      if (!lock_s) begin
        m_run       = 1'b0;
        m_loss_evt  = 1'b1;
        m_hold_left = HC;
      end
    end else begin
      m_streak = lock_s ? m_streak + 1 : 0;
      // One lock cycle seen in WAIT plus a full window of STABLE_CYCLES qualifies.
      if (m_streak == SC + 1) begin
        m_run    = 1'b1;
        m_streak = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit lk);
    reset        = r;
    bus.locked_i = lk;
    @(posedge clk);
    model_edge(r, lk);
    @(negedge clk);
    chk("rst_o", bus.rst_o, e_rst);
    chk("ready_o", bus.ready_o, !e_rst);
    chk("lock_loss_o", bus.lock_loss_o, e_loss);
    chk("loss_count_o", bus.loss_count_o, e_cnt);
    if (bus.lock_loss_o === 1'b1) obs_pulses++;
  endtask

  // Hold lock high for 60 cycles (optionally one low cycle at glitch_at); report first cycle with rst_o low.
  task automatic run_seq(input int glitch_at, output int found);
    found = -1;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, (i == glitch_at) ? 1'b0 : 1'b1);
      if (found < 0 && bus.rst_o === 1'b0) found = i;
    end
  endtask

  initial begin
    int f;
    int hi;
    int p0;
    int hi_left;
    bit lk;

    reset        = 1'b1;
    bus.locked_i = 1'b0;
    @(negedge clk);

    repeat (3) step(1'b1, 1'b0);
    chk("reset_rst", bus.rst_o, 1);
    chk("reset_ready", bus.ready_o, 0);

    // Plain release: 2 sync + 1 WAIT + 16 qualify cycles after reset drops.
    run_seq(0, f);
    chk("release_lat", f - 1, SS + 1 + SC);

    // One-cycle lock glitch inside QUALIFY restarts the full window.
    repeat (2) step(1'b1, 1'b1);
    run_seq(11, f);
    chk("glitch_release", f, 11 + SS + 2 + SC);

    // Lock loss in RUN, lock back next cycle: one pulse, HOLD+WAIT+QUALIFY of reset.
    p0 = obs_pulses;
    step(1'b0, 1'b0);
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1);
      if (bus.rst_o === 1'b1) hi++;
    end
    chk("hold_len", hi, HC + 1 + SC);
    chk("loss_pulses", obs_pulses - p0, 1);
    chk("loss_count_1", bus.loss_count_o, CNT_EN ? 1 : 0);

    // Reset mid-QUALIFY aborts qualification.
    repeat (2) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("abort_q_rst", bus.rst_o, 1);
    run_seq(0, f);
    chk("abort_q_release", f - 1, SS + 1 + SC);

    // Reset mid-HOLD aborts the hold and clears the loss count.
    step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("abort_h_cnt", bus.loss_count_o, 0);
    chk("abort_h_loss", bus.lock_loss_o, 0);
    run_seq(0, f);
    chk("abort_h_release", f - 1, SS + 1 + SC);

    // 300 losses: counter saturates (or stays 0 when not built).
    p0 = obs_pulses;
    for (int n = 0; n < 300; n++) begin
      step(1'b0, 1'b0);
      repeat (28) step(1'b0, 1'b1);
    end
    chk("sat_pulses", obs_pulses - p0, 300);
    chk("sat_count", bus.loss_count_o, CNT_EN ? CNT_MAX : 0);

    // Random lock bursts, glitches and occasional reset pulses.
    hi_left = 0;
    lk      = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (hi_left == 0) begin
        lk      = ~lk;
        hi_left = lk ? $urandom_range(1, 60) : $urandom_range(1, 6);
      end
      hi_left--;
      step(($urandom_range(0, 199) == 0), lk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
